// File: rtl/rv_pkg.sv
// Shared integer register-file constants and the default architectural address type.
package rv_pkg;
  localparam int RV_XLEN     = 32;
  localparam int RV_NUM_REGS = 32;
  localparam int RV_NUM_RD   = 3;
  localparam int RV_AW       = $clog2(RV_NUM_REGS);

  typedef logic [RV_AW-1:0] reg_addr_t;
endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: write-back bypass mux plus hazard qualification.
module regfile_rd_port
  import rv_pkg::*;
#(
  parameter int XLEN     = RV_XLEN,
  parameter int NUM_REGS = RV_NUM_REGS,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rd_en,
  input  logic [AW-1:0]            rd_addr,
  input  logic [NUM_REGS*XLEN-1:0] regs,
  input  logic [NUM_REGS-1:0]      pending,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [XLEN-1:0]          wr_data,
  output logic [XLEN-1:0]          rd_data,
  output logic                     rd_hazard
);

  logic            wr_hit_s;
  logic [XLEN-1:0] byp_data_s;
  logic            byp_haz_s;
  logic [XLEN-1:0] rd_data_r;
  logic            rd_hazard_r;

  // Bypass select; slot 0 of regs is held at zero so x0 needs no special case on the stored path.
  always_comb begin
    wr_hit_s = wr_en && (wr_addr == rd_addr);
    if (wr_hit_s && (rd_addr != {AW{1'b0}})) begin
      byp_data_s = wr_data;
    end else begin
      byp_data_s = regs[rd_addr*XLEN +: XLEN];
    end
    byp_haz_s = pending[rd_addr] && !wr_hit_s;
  end

  // Output flops; a disabled port returns zero data and no hazard.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_r   <= {XLEN{1'b0}};
      rd_hazard_r <= 1'b0;
    end else if (rd_en) begin
      rd_data_r   <= byp_data_s;
      rd_hazard_r <= byp_haz_s;
    end else begin
      rd_data_r   <= {XLEN{1'b0}};
      rd_hazard_r <= 1'b0;
    end
  end

  assign rd_data   = rd_data_r;
  assign rd_hazard = rd_hazard_r;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with hard-wired x0, write-back bypass and
// a per-register pending scoreboard for read-after-write hazard detection.
module regfile_mp
  import rv_pkg::*;
#(
  parameter int XLEN     = RV_XLEN,
  parameter int NUM_REGS = RV_NUM_REGS,
  parameter int NUM_RD   = RV_NUM_RD,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_RD-1:0]      rd_en,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  output logic [NUM_RD-1:0]      rd_hazard,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [XLEN-1:0]        wr_data,
  input  logic                   mark_en,
  input  logic [AW-1:0]          mark_addr,
  output logic                   any_pending
);

  logic [NUM_REGS*XLEN-1:0] regs_r;
  logic [NUM_REGS-1:0]      pending_r;
  logic [NUM_REGS-1:0]      pending_nxt_s;
  logic [NUM_REGS-1:0]      wr_sel_s;
  logic [NUM_REGS-1:0]      mark_sel_s;
  logic                     any_pending_r;

  // One-hot write/mark selects; x0 never selects. Mark is OR-ed last so a new producer wins.
  always_comb begin
    if (wr_en && (wr_addr != {AW{1'b0}})) begin
      wr_sel_s = {{(NUM_REGS-1){1'b0}}, 1'b1} << wr_addr;
    end else begin
      wr_sel_s = {NUM_REGS{1'b0}};
    end
    if (mark_en && (mark_addr != {AW{1'b0}})) begin
      mark_sel_s = {{(NUM_REGS-1){1'b0}}, 1'b1} << mark_addr;
    end else begin
      mark_sel_s = {NUM_REGS{1'b0}};
    end
    pending_nxt_s = (pending_r & ~wr_sel_s) | mark_sel_s;
  end

  // Architectural storage; slot 0 is never written and stays zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_r <= {(NUM_REGS*XLEN){1'b0}};
    end else if (wr_en && (wr_addr != {AW{1'b0}})) begin
      regs_r[wr_addr*XLEN +: XLEN] <= wr_data;
    end else begin
      regs_r <= regs_r;
    end
  end

  // Scoreboard and its registered summary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_r     <= {NUM_REGS{1'b0}};
      any_pending_r <= 1'b0;
    end else begin
      pending_r     <= pending_nxt_s;
      any_pending_r <= |pending_nxt_s;
    end
  end

  assign any_pending = any_pending_r;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    regfile_rd_port #(
      .XLEN     (XLEN),
      .NUM_REGS (NUM_REGS),
      .AW       (AW)
    ) u_rd_port (
      .clk       (clk),
      .rst       (rst),
      .rd_en     (rd_en[p]),
      .rd_addr   (rd_addr[p*AW +: AW]),
      .regs      (regs_r),
      .pending   (pending_r),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_data   (rd_data[p*XLEN +: XLEN]),
      .rd_hazard (rd_hazard[p])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench driving a default regfile_mp and a 64-bit/16-reg/4-port one with the same steps.
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [2:0]   rd_en_a;
  logic [14:0]  rd_addr_a;
  logic [95:0]  rd_data_a;
  logic [2:0]   rd_hazard_a;
  logic         wr_en_a;
  logic [4:0]   wr_addr_a;
  logic [31:0]  wr_data_a;
  logic         mark_en_a;
  logic [4:0]   mark_addr_a;
  logic         any_pending_a;

  logic [3:0]   rd_en_b;
  logic [15:0]  rd_addr_b;
  logic [255:0] rd_data_b;
  logic [3:0]   rd_hazard_b;
  logic         wr_en_b;
  logic [3:0]   wr_addr_b;
  logic [63:0]  wr_data_b;
  logic         mark_en_b;
  logic [3:0]   mark_addr_b;
  logic         any_pending_b;

  int checks = 0;
  int errors = 0;

  regfile_mp u_a (
    .clk(clk), .rst(rst),
    .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a), .rd_hazard(rd_hazard_a),
    .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
    .mark_en(mark_en_a), .mark_addr(mark_addr_a), .any_pending(any_pending_a)
  );

  regfile_mp #(.XLEN(64), .NUM_REGS(16), .NUM_RD(4)) u_b (
    .clk(clk), .rst(rst),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b), .rd_hazard(rd_hazard_b),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .mark_en(mark_en_b), .mark_addr(mark_addr_b), .any_pending(any_pending_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rd_en_a = 3'b000; rd_addr_a = 15'h0000; wr_en_a = 1'b0; wr_addr_a = 5'd0;
    wr_data_a = 32'h0; mark_en_a = 1'b0; mark_addr_a = 5'd0;
    rd_en_b = 4'b0000; rd_addr_b = 16'h0000; wr_en_b = 1'b0; wr_addr_b = 4'd0;
    wr_data_b = 64'h0; mark_en_b = 1'b0; mark_addr_b = 4'd0;
  endtask

  task automatic set_rd(input int p, input logic en, input int addr);
    if (p < 3) begin
      rd_en_a[p] = en;
      rd_addr_a[p*5 +: 5] = 5'(addr);
    end
    rd_en_b[p] = en;
    rd_addr_b[p*4 +: 4] = 4'(addr);
  endtask

  task automatic set_wr(input int addr, input logic [63:0] d);
    wr_en_a = 1'b1; wr_addr_a = 5'(addr); wr_data_a = d[31:0];
    wr_en_b = 1'b1; wr_addr_b = 4'(addr); wr_data_b = d;
  endtask

  task automatic set_mark(input int addr);
    mark_en_a = 1'b1; mark_addr_a = 5'(addr);
    mark_en_b = 1'b1; mark_addr_b = 4'(addr);
  endtask

  task automatic chk_rd(input string tag, input int p, input logic [63:0] exp_d, input logic exp_h);
    if (p < 3) begin
      chk({tag, "_data_a"}, 256'(rd_data_a[p*32 +: 32]), 256'(exp_d[31:0]));
      chk({tag, "_haz_a"}, 256'(rd_hazard_a[p]), 256'(exp_h));
    end
    chk({tag, "_data_b"}, 256'(rd_data_b[p*64 +: 64]), 256'(exp_d));
    chk({tag, "_haz_b"}, 256'(rd_hazard_b[p]), 256'(exp_h));
  endtask

  task automatic chk_any(input string tag, input logic exp);
    chk({tag, "_any_a"}, 256'(any_pending_a), 256'(exp));
    chk({tag, "_any_b"}, 256'(any_pending_b), 256'(exp));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdata_a"}, 256'(rd_data_a), 256'h0);
    chk({tag, "_rdata_b"}, rd_data_b, 256'h0);
    chk({tag, "_rhaz_a"}, 256'(rd_hazard_a), 256'h0);
    chk({tag, "_rhaz_b"}, 256'(rd_hazard_b), 256'h0);
    chk_any(tag, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b0;

    // Populate state so the mid-stream reset has something to clear.
    set_wr(1, 64'h8000_0000_0000_00AA);
    set_mark(2);
    tick();
    idle();
    set_rd(0, 1'b1, 1);
    tick();
    chk_rd("pre_rst", 0, 64'h8000_0000_0000_00AA, 1'b0);
    chk_any("pre_rst", 1'b1);

    #2 rst = 1'b1;
    #1;
    chk_all_zero("rst_async");
    set_wr(1, 64'h1111_2222_3333_4444);
    set_mark(4);
    set_rd(0, 1'b1, 1);
    tick();
    chk_all_zero("rst_held");
    rst = 1'b0;
    idle();

    for (int a = 1; a < 32; a++) begin
      idle();
      set_rd(0, 1'b1, a);
      set_rd(1, 1'b1, a);
      tick();
      chk_rd("post_rst_p0", 0, 64'h0, 1'b0);
      chk_rd("post_rst_p1", 1, 64'h0, 1'b0);
      chk_any("post_rst", 1'b0);
    end

    // x0 ignores writes, both through bypass and storage.
    idle();
    set_wr(0, 64'hDEAD_BEEF_DEAD_BEEF);
    set_rd(1, 1'b1, 0);
    tick();
    chk_rd("x0_bypass", 1, 64'h0, 1'b0);
    idle();
    set_rd(0, 1'b1, 0);
    tick();
    chk_rd("x0_read", 0, 64'h0, 1'b0);

    // Read-enable gating.
    idle();
    set_wr(5, 64'h0BAD_F00D_1234_5678);
    tick();
    idle();
    set_rd(0, 1'b1, 5);
    set_rd(1, 1'b0, 5);
    set_rd(2, 1'b1, 5);
    set_rd(3, 1'b0, 5);
    tick();
    chk_rd("gate_p0", 0, 64'h0BAD_F00D_1234_5678, 1'b0);
    chk_rd("gate_p1", 1, 64'h0, 1'b0);
    chk_rd("gate_p2", 2, 64'h0BAD_F00D_1234_5678, 1'b0);
    chk_rd("gate_p3", 3, 64'h0, 1'b0);

    // All ports on the same address.
    idle();
    for (int p = 0; p < 4; p++) set_rd(p, 1'b1, 5);
    tick();
    for (int p = 0; p < 4; p++) chk_rd("same_addr", p, 64'h0BAD_F00D_1234_5678, 1'b0);

    // Same-edge write-to-read bypass.
    idle();
    set_wr(7, 64'hA5A5_A5A5_5A5A_5A5A);
    set_rd(1, 1'b1, 7);
    tick();
    chk_rd("bypass", 1, 64'hA5A5_A5A5_5A5A_5A5A, 1'b0);

    // Mark and read on the same edge: no hazard yet.
    idle();
    set_mark(3);
    set_rd(0, 1'b1, 3);
    tick();
    chk_rd("mark_same", 0, 64'h0, 1'b0);
    chk_any("mark_same", 1'b1);
    idle();
    set_rd(0, 1'b1, 3);
    tick();
    chk_rd("mark_later", 0, 64'h0, 1'b1);
    chk_any("mark_later", 1'b1);

    // Write clears pending and suppresses the same-edge hazard.
    idle();
    set_wr(3, 64'h1);
    set_rd(0, 1'b1, 3);
    tick();
    chk_rd("wr_clear", 0, 64'h1, 1'b0);
    chk_any("wr_clear", 1'b0);

    // Mark and write the same register: new producer wins.
    idle();
    set_wr(9, 64'h55);
    set_mark(9);
    tick();
    chk_any("mark_wr", 1'b1);
    idle();
    set_rd(2, 1'b1, 9);
    tick();
    chk_rd("mark_wr", 2, 64'h55, 1'b1);
    idle();
    set_wr(9, 64'h66);
    tick();
    chk_any("mark_wr_clr", 1'b0);

    // Marking x0 does nothing.
    idle();
    set_mark(0);
    tick();
    chk_any("mark_x0", 1'b0);
    idle();
    set_rd(0, 1'b1, 0);
    tick();
    chk_rd("mark_x0", 0, 64'h0, 1'b0);

    // Top register, full width.
    idle();
    set_wr(15, 64'hFFFF_FFFF_0000_0001);
    tick();
    idle();
    set_rd(0, 1'b1, 15);
    set_rd(3, 1'b1, 15);
    tick();
    chk_rd("x15_p0", 0, 64'hFFFF_FFFF_0000_0001, 1'b0);
    chk_rd("x15_p3", 3, 64'hFFFF_FFFF_0000_0001, 1'b0);

    // Previously written values persisted.
    idle();
    set_rd(0, 1'b1, 7);
    set_rd(1, 1'b1, 3);
    set_rd(2, 1'b1, 9);
    tick();
    chk_rd("keep_x7", 0, 64'hA5A5_A5A5_5A5A_5A5A, 1'b0);
    chk_rd("keep_x3", 1, 64'h1, 1'b0);
    chk_rd("keep_x9", 2, 64'h66, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
